mult_iter: RTL

- Iterative shift-add multiplier, parametrised in operand width and in bits retired per cycle.
- Serves the multicycle CPU's MULT/MULTU path, with a start/busy/done handshake and a selectable signed or unsigned mode.
- Replaces the fixed-width, free-running tree multiplier that has no handshake.
- The full 2*WIDTH product is registered and held until the next accepted operation.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_step.sv | 29 ++
 rtl/mult_iter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int n_iter(input int width, input int step);
        return width / step;
    endfunction

    function automatic int cnt_w(input int width, input int step);
        return $clog2(width / step + 1);
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds multiplicand * STEP multiplier bits, aligned
// to the current bit position, into the double-width accumulator.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int PW   = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [STEP-1:0]    bits,
    input  logic [PW-1:0]      pos,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++) begin
            if (bits[i]) begin
                pp = pp + ({{WIDTH{1'b0}}, mcand} << i);
            end
        end
        acc_next = acc + (pp << pos);
    end

endmodule

// File: rtl/mult_iter.sv
// Iterative multiplier with start/busy/done handshake; signed mode works on
// magnitudes and negates the finished product when the signs differ.
module mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int N  = n_iter(WIDTH, STEP);
    localparam int CW = cnt_w(WIDTH, STEP);
    localparam int PW = $clog2(WIDTH);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      pos;
    logic               neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    assign busy  = (state != IDLE);

    mult_step #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_step (
        .acc     (acc),
        .mcand   (mcand),
        .bits    (mplier[STEP-1:0]),
        .pos     (pos),
        .acc_next(acc_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: if (cnt == CW'(1)) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            pos    <= '0;
            neg    <= 1'b0;
            z      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CW'(N);
                        pos    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nx;
                    mplier <= mplier >> STEP;
                    cnt    <= cnt - CW'(1);
                    pos    <= pos + PW'(STEP);
                end
                FIN: begin
                    z    <= neg ? -acc : acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
